// File: rtl/instr_loader.sv
// Program loader: streams instruction words into the instruction memory over a
// valid/ready handshake and holds the CPU in run-inhibit until the program is in.
module instr_loader #(
  parameter int unsigned data_size    = 32,
  parameter int unsigned address_size = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [address_size:0]   word_count,
  input  logic                    in_valid,
  input  logic [data_size-1:0]    in_data,
  output logic                    in_ready,
  output logic [31:0]             mem_address,
  output logic [data_size-1:0]    mem_data_in,
  output logic                    mem_write,
  output logic                    busy,
  output logic                    done,
  output logic                    cpu_run
);

  localparam int unsigned IW    = address_size;
  localparam int unsigned CW    = address_size + 1;
  localparam int unsigned DEPTH = 1 << address_size;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] index;
  logic [CW-1:0] remaining;
  logic [CW-1:0] clip_count;
  logic          load_start;
  logic          accept;

  // Requested length clipped to the memory depth
  assign clip_count = (word_count > CW'(DEPTH)) ? CW'(DEPTH) : word_count;
  // A start only counts while the loader is not busy
  assign load_start = start & ((state == IDLE) | (state == DONE));
  // A beat is taken on an edge where the source is valid and we are ready
  assign accept     = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = (clip_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && (remaining == CW'(1))) begin
          next_state = FLUSH;
        end
      end
      FLUSH:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_run  = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FLUSH: busy = 1'b1;
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      default: ;
    endcase
  end

  // Write datapath: present each accepted word one cycle later, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      index       <= '0;
      remaining   <= '0;
    end else begin
      mem_write <= accept;
      if (load_start) begin
        index     <= '0;
        remaining <= clip_count;
      end else if (accept) begin
        mem_data_in <= in_data;
        mem_address <= 32'({index, 2'b00});
        index       <= index + IW'(1);
        remaining   <= remaining - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader with a transaction-level reference model.
module tb_instr_loader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [31:0]   mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_write;
  logic          busy;
  logic          done;
  logic          cpu_run;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tbmem  [DEPTH];
  logic [31:0] expmem [DEPTH];

  always #5 clk = ~clk;

  instr_loader #(.data_size(DW), .address_size(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .word_count  (word_count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_write   (mem_write),
    .busy        (busy),
    .done        (done),
    .cpu_run     (cpu_run)
  );

  // Instruction memory stand-in: captures writes on the rising edge
  always @(posedge clk) begin
    if (mem_write) tbmem[mem_address[6:2]] <= mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete load: vmode 0 = back-to-back, 1 = random gaps, 2 = fixed 1,0,0,1,0,1
  // dmode 0 = random data, 1 = 0x11111111*(i+1), 2 = 0xDEADBEEF
  task automatic run_load(input int wc, input int vmode, input int dmode);
    int          n;
    int          acc;
    int          cyc;
    int          pat [6];
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    logic [31:0] d;
    pat = '{1, 0, 0, 1, 0, 1};
    n   = (wc > DEPTH) ? DEPTH : wc;
    @(negedge clk);
    start      = 1'b1;
    word_count = (AW+1)'(wc);
    in_valid   = 1'b1;
    in_data    = 32'hBAD0_0000;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    if (n == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_cpu_run", 32'(cpu_run), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_write", 32'(mem_write), 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
      check("zero_no_write", 32'(mem_write), 32'd0);
      check("zero_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      return;
    end
    acc  = 0;
    cyc  = 0;
    pend = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    while (acc < n) begin
      if (cyc > 2000) begin
        check("load_timeout", 32'(acc), 32'(n));
        return;
      end
      check("ld_ready", 32'(in_ready), 32'd1);
      check("ld_busy", 32'(busy), 32'd1);
      check("ld_done", 32'(done), 32'd0);
      check("ld_cpu_run", 32'(cpu_run), 32'd0);
      check("ld_write", 32'(mem_write), 32'(pend));
      if (pend) begin
        check("ld_addr", mem_address, pend_addr);
        check("ld_data", mem_data_in, pend_data);
      end
      unique case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ($urandom_range(0, 1) == 1);
        default: in_valid = (pat[cyc % 6] == 1);
      endcase
      unique case (dmode)
        0:       d = $urandom;
        1:       d = 32'h1111_1111 * 32'(acc + 1);
        default: d = 32'hDEAD_BEEF;
      endcase
      in_data = d;
      start   = (vmode == 1) && ($urandom_range(0, 7) == 0);
      word_count = (AW+1)'($urandom_range(0, 40));
      if (in_valid) begin
        pend        = 1'b1;
        pend_addr   = 32'(acc * 4);
        pend_data   = d;
        expmem[acc] = d;
        acc++;
      end else begin
        pend = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    // Last word presented, start and surplus source words must be ignored
    check("fl_write", 32'(mem_write), 32'd1);
    check("fl_addr", mem_address, pend_addr);
    check("fl_data", mem_data_in, pend_data);
    check("fl_ready", 32'(in_ready), 32'd0);
    check("fl_busy", 32'(busy), 32'd1);
    check("fl_done", 32'(done), 32'd0);
    start      = 1'b1;
    word_count = 6'd5;
    in_valid   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("dn_done", 32'(done), 32'd1);
    check("dn_cpu_run", 32'(cpu_run), 32'd1);
    check("dn_busy", 32'(busy), 32'd0);
    check("dn_ready", 32'(in_ready), 32'd0);
    check("dn_write", 32'(mem_write), 32'd0);
    check("dn_addr_hold", mem_address, 32'((n - 1) * 4));
    @(negedge clk);
    check("dn_surplus_write", 32'(mem_write), 32'd0);
    check("dn_stay", 32'(done), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("mem[%0d]", i), tbmem[i], expmem[i]);
    end
  endtask

  initial begin
    logic [31:0] w0, w1;
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_data", mem_data_in, 32'd0);
    rst_n = 1'b1;

    // Source valid with no start must not write
    in_valid = 1'b1;
    in_data  = 32'h5555_5555;
    repeat (4) begin
      @(negedge clk);
      check("idle_write", 32'(mem_write), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;

    run_load(4, 0, 1);
    run_load(3, 2, 0);
    run_load(40, 0, 0);

    // Abort after three accepted beats
    @(negedge clk);
    start      = 1'b1;
    word_count = 6'd8;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    w0 = $urandom;
    w1 = $urandom;
    in_data = w0;
    @(negedge clk);
    in_data = w1;
    @(negedge clk);
    in_data = $urandom;
    @(negedge clk);
    check("abort_pre_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_write", 32'(mem_write), 32'd0);
    check("abort_addr", mem_address, 32'd0);
    check("abort_data", mem_data_in, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_cpu_run", 32'(cpu_run), 32'd0);
    in_valid = 1'b0;
    check("abort_mem0", tbmem[0], w0);
    check("abort_mem1", tbmem[1], w1);
    @(negedge clk);
    rst_n = 1'b1;

    run_load(2, 0, 0);

    // Zero-length load from IDLE
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_load(0, 0, 0);

    run_load(5, 1, 0);
    run_load(1, 0, 2);

    for (int k = 0; k < 6; k++) begin
      run_load($urandom_range(0, 40), 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
